pc_sequencer: RTL and testbench

//  Owns the program counter register and decides each cycle what the next PC is.

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 43 ++++
 rtl/pc_sequencer_next_mux.sv | 65 ++++++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the PC sequencer slice:
//   - default datapath width and the default reset/trap vectors
//   - sequencer state encoding (BOOT / RUN / HALT)
//   - small helper that flags a word-misaligned target address
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int          DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        SEQ_BOOT = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HALT = 2'd2
    } seq_state_e;

    // Instructions are 32-bit aligned, so any set bit in [1:0] is a bad target.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the request inputs coming from execute and the fetch-side outputs of
// the PC sequencer.
//   master : the execute/debug side; drives stall, jump, branch, halt and
//            resume requests and observes PC and status.
//   slave  : the sequencer itself.
// Signals:
//   stall, jump, jump_target, branch_taken, branch_target, halt_req, resume
//   PC, PCPlus4, fetch_valid, halted, trap, epc, instr_count
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            halt_req;
    logic            resume;

    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic            fetch_valid;
    logic            halted;
    logic            trap;
    logic [XLEN-1:0] epc;
    logic [31:0]     instr_count;

    modport master (
        output stall, jump, jump_target, branch_taken, branch_target,
               halt_req, resume,
        input  PC, PCPlus4, fetch_valid, halted, trap, epc, instr_count
    );

    modport slave (
        input  stall, jump, jump_target, branch_taken, branch_target,
               halt_req, resume,
        output PC, PCPlus4, fetch_valid, halted, trap, epc, instr_count
    );

endinterface

// File: rtl/pc_sequencer_next_mux.sv
// -----------------------------------------------------------------------------
// pc_sequencer_next_mux
// Purely combinational next-PC selection for the RUN state.
// Ports:
//   pc_i             current PC
//   run_i            sequencer is in RUN (requests are only honoured there)
//   stall_i          hold everything this cycle
//   jump_i / jump_target_i          jump request and destination
//   branch_taken_i / branch_target_i taken branch and destination
//   halt_req_i       ECALL/EBREAK retiring
//   next_pc_o        PC to load when advance_o is set (held PC otherwise)
//   pc_plus4_o       PC + 4, wrapping
//   misaligned_o     redirect target is misaligned -> trap this edge
//   advance_o        an instruction retires this edge
// -----------------------------------------------------------------------------
module pc_sequencer_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN        = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            run_i,
    input  logic            stall_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            halt_req_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misaligned_o,
    output logic            advance_o
);

    logic [XLEN-1:0] target;
    logic            redirect;

    assign pc_plus4_o = pc_i + XLEN'(4);
    // Jump outranks branch when both resolve in the same cycle.
    assign target     = jump_i ? jump_target_i : branch_target_i;
    assign redirect   = jump_i | branch_taken_i;
    assign advance_o  = run_i & ~stall_i;

    always_comb begin
        next_pc_o    = pc_i;
        misaligned_o = 1'b0;
        if (advance_o) begin
            if (halt_req_i) begin
                // The halting instruction still retires; resume fetches after it.
                next_pc_o = pc_plus4_o;
            end else if (redirect) begin
                if (is_misaligned(target[1:0])) begin
                    next_pc_o    = TRAP_VECTOR;
                    misaligned_o = 1'b1;
                end else begin
                    next_pc_o = target;
                end
            end else begin
                next_pc_o = pc_plus4_o;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter and the BOOT/RUN/HALT state. Next-PC selection is
// delegated to pc_sequencer_next_mux; this module keeps the state, PC, epc,
// trap pulse and retired-instruction counter registers.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active low
//   bus    pc_sequencer_if.slave: request inputs and PC/status outputs
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            trap_q, trap_d;
    logic [31:0]     count_q, count_d;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned;
    logic            advance;
    logic            in_run;

    assign in_run = (state_q == SEQ_RUN);

    pc_sequencer_next_mux #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_mux (
        .pc_i            (pc_q),
        .run_i           (in_run),
        .stall_i         (bus.stall),
        .jump_i          (bus.jump),
        .jump_target_i   (bus.jump_target),
        .branch_taken_i  (bus.branch_taken),
        .branch_target_i (bus.branch_target),
        .halt_req_i      (bus.halt_req),
        .next_pc_o       (next_pc),
        .pc_plus4_o      (pc_plus4),
        .misaligned_o    (misaligned),
        .advance_o       (advance)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        trap_d  = 1'b0;          // trap is a single-cycle pulse
        count_d = count_q;

        unique case (state_q)
            SEQ_BOOT: state_d = SEQ_RUN;
            SEQ_RUN:  if (advance && bus.halt_req) state_d = SEQ_HALT;
            // resume is honoured regardless of stall.
            SEQ_HALT: if (bus.resume) state_d = SEQ_RUN;
            default:  state_d = SEQ_BOOT;
        endcase

        if (advance) begin
            pc_d    = next_pc;
            count_d = count_q + 32'd1;
            if (misaligned) begin
                epc_d  = pc_q;
                trap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            trap_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            trap_q  <= trap_d;
            count_q <= count_d;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_plus4;
    assign bus.fetch_valid = in_run;
    assign bus.halted      = (state_q == SEQ_HALT);
    assign bus.trap        = trap_q;
    assign bus.epc         = epc_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Two sequencers (default reset vector, and a reset vector just below the top
// of the address space) see identical stimulus. The driver applies inputs on
// the falling edge, steps a reference model and queues the expected outputs;
// the monitor pops and compares one entry per DUT after each rising edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RV_A = 32'h0000_0000;
    localparam logic [31:0] RV_B = 32'hFFFF_FFF8;
    localparam logic [31:0] TV   = 32'h0000_0100;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.XLEN(32)) ifa ();
    pc_sequencer_if #(.XLEN(32)) ifb ();

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV_A), .TRAP_VECTOR(TV)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV_B), .TRAP_VECTOR(TV)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        stall;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        halt;
        logic        resume;
    } stim_t;

    // Reference model state: a mode flag pair plus architectural registers.
    typedef struct packed {
        logic        booting;
        logic        stopped;
        logic        trapped;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] cnt;
    } mdl_t;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        fv;
        logic        hl;
        logic        tr;
        logic [31:0] epc;
        logic [31:0] cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    mdl_t ma, mb;

    int vectors     = 0;
    int miscompares = 0;

    function automatic stim_t st(input logic r, input logic s, input logic j,
                                 input logic [31:0] jt, input logic b,
                                 input logic [31:0] bt, input logic h,
                                 input logic res);
        stim_t x;
        x.rst_n = r; x.stall = s; x.jump = j; x.jt = jt;
        x.br = b; x.bt = bt; x.halt = h; x.resume = res;
        return x;
    endfunction

    // One clock of architectural behaviour, straight from the sequencing rules.
    function automatic mdl_t step(input mdl_t s, input stim_t x, input logic [31:0] rv);
        mdl_t        n;
        logic [31:0] t;
        n = s;
        n.trapped = 1'b0;
        if (!x.rst_n) begin
            n.booting = 1'b1; n.stopped = 1'b0;
            n.pc = rv; n.epc = 32'd0; n.cnt = 32'd0;
        end else if (s.booting) begin
            n.booting = 1'b0;
        end else if (s.stopped) begin
            if (x.resume) n.stopped = 1'b0;
        end else if (!x.stall) begin
            n.cnt = s.cnt + 32'd1;
            if (x.halt) begin
                n.pc = s.pc + 32'd4;
                n.stopped = 1'b1;
            end else if (x.jump || x.br) begin
                t = x.jump ? x.jt : x.bt;
                if ((t % 4) != 0) begin
                    n.epc = s.pc;
                    n.pc = TV;
                    n.trapped = 1'b1;
                end else begin
                    n.pc = t;
                end
            end else begin
                n.pc = s.pc + 32'd4;
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_of(input mdl_t m, input string tag);
        exp_t e;
        e.tag = tag;
        e.pc = m.pc; e.pcp4 = m.pc + 32'd4;
        e.fv = !m.booting && !m.stopped;
        e.hl = m.stopped; e.tr = m.trapped;
        e.epc = m.epc; e.cnt = m.cnt;
        return e;
    endfunction

    function automatic exp_t snap(input int idx);
        exp_t a;
        a.tag = "";
        if (idx == 0) begin
            a.pc = ifa.PC; a.pcp4 = ifa.PCPlus4; a.fv = ifa.fetch_valid;
            a.hl = ifa.halted; a.tr = ifa.trap; a.epc = ifa.epc; a.cnt = ifa.instr_count;
        end else begin
            a.pc = ifb.PC; a.pcp4 = ifb.PCPlus4; a.fv = ifb.fetch_valid;
            a.hl = ifb.halted; a.tr = ifb.trap; a.epc = ifb.epc; a.cnt = ifb.instr_count;
        end
        return a;
    endfunction

    task automatic check(input string who, input exp_t e, input exp_t a);
        int bad;
        bad = 0;
        if (a.pc !== e.pc) begin
            $display("FAIL %s %s PC got %h want %h", who, e.tag, a.pc, e.pc); bad++;
        end
        if (a.pcp4 !== e.pcp4) begin
            $display("FAIL %s %s PCPlus4 got %h want %h", who, e.tag, a.pcp4, e.pcp4); bad++;
        end
        if (a.fv !== e.fv) begin
            $display("FAIL %s %s fetch_valid got %b want %b", who, e.tag, a.fv, e.fv); bad++;
        end
        if (a.hl !== e.hl) begin
            $display("FAIL %s %s halted got %b want %b", who, e.tag, a.hl, e.hl); bad++;
        end
        if (a.tr !== e.tr) begin
            $display("FAIL %s %s trap got %b want %b", who, e.tag, a.tr, e.tr); bad++;
        end
        if (a.epc !== e.epc) begin
            $display("FAIL %s %s epc got %h want %h", who, e.tag, a.epc, e.epc); bad++;
        end
        if (a.cnt !== e.cnt) begin
            $display("FAIL %s %s instr_count got %0d want %0d", who, e.tag, a.cnt, e.cnt); bad++;
        end
        vectors++;
        if (bad != 0) miscompares++;
    endtask

    // Monitor: one comparison per DUT after every rising edge that has an
    // outstanding expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() != 0) begin
                e = qa.pop_front();
                a = snap(0);
                check("A", e, a);
                $display("[%0t] %-12s A pc=%h fv=%b hl=%b tr=%b cnt=%0d", $time, e.tag,
                         a.pc, a.fv, a.hl, a.tr, a.cnt);
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                a = snap(1);
                check("B", e, a);
                $display("[%0t] %-12s B pc=%h fv=%b hl=%b tr=%b cnt=%0d", $time, e.tag,
                         a.pc, a.fv, a.hl, a.tr, a.cnt);
            end
        end
    end

    task automatic cyc(input stim_t x, input string tag);
        @(negedge clk);
        rst_n = x.rst_n;
        ifa.stall = x.stall; ifa.jump = x.jump; ifa.jump_target = x.jt;
        ifa.branch_taken = x.br; ifa.branch_target = x.bt;
        ifa.halt_req = x.halt; ifa.resume = x.resume;
        ifb.stall = x.stall; ifb.jump = x.jump; ifb.jump_target = x.jt;
        ifb.branch_taken = x.br; ifb.branch_target = x.bt;
        ifb.halt_req = x.halt; ifb.resume = x.resume;
        ma = step(ma, x, RV_A);
        mb = step(mb, x, RV_B);
        qa.push_back(expect_of(ma, tag));
        qb.push_back(expect_of(mb, tag));
    endtask

    task automatic idle(input string tag);
        cyc(st(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0), tag);
    endtask

    initial begin
        logic [31:0] r;
        stim_t       x;

        rst_n = 1'b0;
        ifa.stall = 1'b0; ifa.jump = 1'b0; ifa.jump_target = '0;
        ifa.branch_taken = 1'b0; ifa.branch_target = '0;
        ifa.halt_req = 1'b0; ifa.resume = 1'b0;
        ifb.stall = 1'b0; ifb.jump = 1'b0; ifb.jump_target = '0;
        ifb.branch_taken = 1'b0; ifb.branch_target = '0;
        ifb.halt_req = 1'b0; ifb.resume = 1'b0;
        ma = '0; ma.booting = 1'b1;
        mb = '0; mb.booting = 1'b1;

        // Reset, boot, then sequential fetch (B wraps through zero here).
        repeat (2) cyc(st(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0), "reset");
        idle("boot");
        idle("seq");
        idle("seq");
        // Stall with jump and branch pending, then both release: jump wins.
        repeat (3) cyc(st(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0), "stall");
        cyc(st(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0), "prio_jump");
        cyc(st(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0), "jump");
        cyc(st(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0), "halt_jump");
        cyc(st(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1), "resume");
        cyc(st(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0), "jump");
        cyc(st(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h32, 1'b0, 1'b0), "trap");
        idle("trap_clear");
        cyc(st(1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 1'b0), "jump");
        cyc(st(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0), "halt");
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            cyc(st(1'b1, r[0], r[1], r, r[2], r ^ 32'h55, r[3], 1'b0), "halted_wait");
        end
        cyc(st(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1), "resume_stall");
        idle("seq");
        cyc(st(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0), "halt");
        cyc(st(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1), "reset_halted");
        idle("boot");
        idle("seq");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            x.rst_n  = ($urandom_range(0, 63) != 0);
            x.stall  = ($urandom_range(0, 3) == 0);
            x.jump   = ($urandom_range(0, 7) == 0);
            x.br     = ($urandom_range(0, 5) == 0);
            x.halt   = ($urandom_range(0, 15) == 0);
            x.resume = ($urandom_range(0, 3) == 0);
            r = $urandom;
            x.jt = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
            r = $urandom;
            x.bt = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
            cyc(x, "random");
        end

        @(negedge clk);
        @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            $display("FAIL drain pending got %0d/%0d want 0/0", qa.size(), qb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
